mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arbiter_rr_arb2.sv | 19 +
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding,
// data-memory geometry defaults and the address window check.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int unsigned DEF_BASE_ADDR = 1024;
    localparam int unsigned DEF_DEPTH     = 64;

    // Word-aligned and inside [base, base + 4*depth); 33-bit compare so a
    // window touching the top of the address space cannot wrap.
    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input int unsigned base,
        input int unsigned depth
    );
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = {1'b0, base} + {1'b0, depth << 2};
        return (a >= lo) && (a < hi) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin selector: one-hot grant, the port not granted last
// wins a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-ported data memory.
// One access per three cycles: IDLE latches a winner, ACCESS strobes memory, RESP acks.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned DEPTH     = DEF_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    input  logic [31:0] mem_result
);

    state_t      state_reg;
    state_t      state_next;

    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        port_reg;
    logic        oor_reg;
    logic        last_reg;
    logic [31:0] rdata_reg;

    logic [1:0]  grant;
    logic        any_grant;
    logic        win_port;
    logic        win_we;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;

    rr_arb2 u_rr_arb2 (
        .req   ({req1, req0}),
        .last  (last_reg),
        .grant (grant)
    );

    assign any_grant = grant[0] | grant[1];
    assign win_port  = grant[1];
    assign win_we    = win_port ? we1    : we0;
    assign win_addr  = win_port ? addr1  : addr0;
    assign win_wdata = win_port ? wdata1 : wdata0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (any_grant) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request is captured only when leaving IDLE, so later req changes
    // (including an early drop) do not affect the transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            port_reg  <= 1'b0;
            oor_reg   <= 1'b0;
        end else if (state_reg == IDLE && any_grant) begin
            we_reg    <= win_we;
            addr_reg  <= win_addr;
            wdata_reg <= win_wdata;
            port_reg  <= win_port;
            oor_reg   <= !addr_in_range(win_addr, BASE_ADDR, DEPTH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (state_reg == ACCESS) begin
            if (oor_reg) begin
                rdata_reg <= '0;
            end else if (!we_reg) begin
                rdata_reg <= mem_result;
            end
        end
    end

    // Pointer starts at 1 so that port 0 takes the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (state_reg == RESP) begin
            last_reg <= port_reg;
        end
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        if (state_reg == ACCESS) begin
            mem_addr = addr_reg;
            if (!oor_reg) begin
                mem_read  = !we_reg;
                mem_write = we_reg;
            end
            if (we_reg) begin
                mem_data = wdata_reg;
            end
        end
    end

    assign ack0  = (state_reg == RESP) && !port_reg;
    assign ack1  = (state_reg == RESP) &&  port_reg;
    assign err0  = ack0 && oor_reg;
    assign err1  = ack1 && oor_reg;
    assign rdata = rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 64-word data memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err0, err1, mem_read, mem_write;
    logic [31:0] rdata, mem_addr, mem_data, mem_result;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:63];
    logic [31:0] mem_off;

    always #5 clk = ~clk;

    assign mem_off    = mem_addr - 32'd1024;
    assign mem_result = mem[mem_off[7:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_off[7:2]] <= mem_data;
    end

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_result(mem_result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge and check the global invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("no_rd_wr_overlap", {31'd0, mem_read & mem_write}, 32'd0);
        chk("no_ack_overlap", {31'd0, ack0 & ack1}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic read_word(input logic [31:0] a, input logic [31:0] exp, input string tag);
        req0 = 1'b1; we0 = 1'b0; addr0 = a;
        tick();
        tick();
        chk({tag, "_ack"}, {31'd0, ack0}, 32'd1);
        chk({tag, "_data"}, rdata, exp);
        req0 = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[2] = 32'hDEADBEEF;

        // Reset state
        #2;
        chk("rst_ack0", {31'd0, ack0}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        tick();
        rst = 1'b0;

        // Single read of word 2
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd1032;
        tick();
        chk("rd_mem_read", {31'd0, mem_read}, 32'd1);
        chk("rd_mem_addr", mem_addr, 32'd1032);
        chk("rd_ack_early", {31'd0, ack0}, 32'd0);
        tick();
        chk("rd_ack0", {31'd0, ack0}, 32'd1);
        chk("rd_err0", {31'd0, err0}, 32'd0);
        chk("rd_rdata", rdata, 32'hDEADBEEF);
        req0 = 1'b0;
        tick();
        chk("rd_ack_pulse", {31'd0, ack0}, 32'd0);
        chk("rd_rdata_hold", rdata, 32'hDEADBEEF);

        // Simultaneous writes after reset: port 0 first, port 1 three cycles later
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd1024; wdata0 = 32'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd1028; wdata1 = 32'h22;
        tick();
        chk("wr_mem_write", {31'd0, mem_write}, 32'd1);
        chk("wr_mem_data", mem_data, 32'h11);
        tick();
        chk("wr_ack0_c2", {31'd0, ack0}, 32'd1);
        chk("wr_ack1_c2", {31'd0, ack1}, 32'd0);
        req0 = 1'b0;
        tick();
        chk("wr_idle_c3", {31'd0, mem_write}, 32'd0);
        tick();
        chk("wr1_mem_addr", mem_addr, 32'd1028);
        tick();
        chk("wr_ack1_c5", {31'd0, ack1}, 32'd1);
        req1 = 1'b0; we1 = 1'b0;
        tick();
        read_word(32'd1024, 32'h11, "rb_w0");
        read_word(32'd1028, 32'h22, "rb_w1");

        // Fairness: both ports request continuously for 12 cycles
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd1032;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd1024;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("fair_ack0_c%0d", c), {31'd0, ack0}, (c == 2 || c == 8) ? 32'd1 : 32'd0);
            chk($sformatf("fair_ack1_c%0d", c), {31'd0, ack1}, (c == 5 || c == 11) ? 32'd1 : 32'd0);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();

        // Out of range: one past the end, misaligned, then the last valid word
        do_reset();
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd1280;
        tick();
        chk("oor_end_strobe", {30'd0, mem_read, mem_write}, 32'd0);
        tick();
        chk("oor_end_ack_err", {30'd0, ack1, err1}, 32'd3);
        chk("oor_end_rdata", rdata, 32'd0);
        req1 = 1'b0;
        tick();
        chk("oor_err_pulse", {31'd0, err1}, 32'd0);
        req1 = 1'b1; addr1 = 32'd1026;
        tick();
        chk("oor_mis_strobe", {30'd0, mem_read, mem_write}, 32'd0);
        tick();
        chk("oor_mis_ack_err", {30'd0, ack1, err1}, 32'd3);
        chk("oor_mis_rdata", rdata, 32'd0);
        req1 = 1'b0;
        tick();
        req1 = 1'b1; addr1 = 32'd1276;
        tick();
        chk("inr_last_read", {31'd0, mem_read}, 32'd1);
        tick();
        chk("inr_last_ack_err", {30'd0, ack1, err1}, 32'd2);
        req1 = 1'b0;
        tick();

        // Reset in the ACCESS cycle aborts the write
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd1036; wdata0 = 32'h55;
        tick();
        chk("abort_access", {31'd0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_async_wr", {31'd0, mem_write}, 32'd0);
        chk("abort_async_addr", mem_addr, 32'd0);
        chk("abort_async_rdata", rdata, 32'd0);
        req0 = 1'b0; we0 = 1'b0;
        tick();
        chk("abort_no_ack0", {31'd0, ack0}, 32'd0);
        rst = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd1032;
        tick();
        chk("post_rst_read", {31'd0, mem_read}, 32'd1);
        chk("post_rst_no_ack0", {31'd0, ack0}, 32'd0);
        tick();
        chk("post_rst_ack1", {31'd0, ack1}, 32'd1);
        chk("post_rst_rdata", rdata, 32'hDEADBEEF);
        req1 = 1'b0;
        tick();

        // Early deassert: req0 drops after cycle 0, ack still arrives
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd1032;
        tick();
        req0 = 1'b0;
        chk("early_read", {31'd0, mem_read}, 32'd1);
        tick();
        chk("early_ack0", {31'd0, ack0}, 32'd1);
        tick();
        chk("early_no_access", {31'd0, mem_read}, 32'd0);
        tick();
        chk("early_no_ack", {31'd0, ack0}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
